// File: rtl/negext_arbiter.sv
// Round-robin arbiter sharing one negate/zero-extend datapath between two requesters; 1-cycle registered result.
// Readys drop while an undrained result is held. Optional res_ovf output under NEGEXT_NEG_OVF_EN.
module negext_arbiter #(
  parameter int DATA_W = 32,
  parameter int EXT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_op,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_op,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  input  logic              res_ready
`ifdef NEGEXT_NEG_OVF_EN
  ,
  output logic              res_ovf
`endif
);

  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
  localparam logic [DATA_W-1:0] MOST_NEG = ONE << (DATA_W - 1);

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;
  logic              res_id_q,    res_id_d;
  logic              prio_q,      prio_d;

  logic              can_accept;
  logic              grant_vld;
  logic              grant_id;
  logic              xfer;
  logic              sel_op;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] op_result;

  always_comb begin
    can_accept = !res_valid_q || res_ready;
    grant_vld  = req0_valid || req1_valid;
    // Contention resolved by the pointer; a lone requester always wins.
    grant_id   = (req0_valid && req1_valid) ? prio_q : req1_valid;
    xfer       = can_accept && grant_vld;
    req0_ready = xfer && !grant_id;
    req1_ready = xfer &&  grant_id;
    sel_op     = grant_id ? req1_op   : req0_op;
    sel_data   = grant_id ? req1_data : req0_data;
    op_result  = sel_op ? (~sel_data + ONE)
                        : {{(DATA_W-EXT_W){1'b0}}, sel_data[EXT_W-1:0]};
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    prio_d      = prio_q;
    if (xfer) begin
      res_valid_d = 1'b1;
      res_data_d  = op_result;
      res_id_d    = grant_id;
      prio_d      = !grant_id;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      prio_q      <= prio_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

`ifdef NEGEXT_NEG_OVF_EN
  logic res_ovf_q, res_ovf_d;

  always_comb begin
    res_ovf_d = res_ovf_q;
    if (xfer) res_ovf_d = sel_op && (sel_data == MOST_NEG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_ovf_q <= 1'b0;
    else        res_ovf_q <= res_ovf_d;
  end

  assign res_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_negext_arbiter.sv
// Bench for negext_arbiter: reference model of the result register plus directed literal checks.
module tb_negext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_op = 1'b0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0, req1_op = 1'b0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_id;
  logic        res_ready = 1'b0;
`ifdef NEGEXT_NEG_OVF_EN
  logic        res_ovf;
`endif

  negext_arbiter #(.DATA_W(32), .EXT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready)
`ifdef NEGEXT_NEG_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of what the consumer should observe.
  bit          m_vld;
  logic [31:0] m_data;
  int          m_id;
  int          m_ptr;
  bit          m_ovf;
  int          last_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_data = '0; m_id = 0; m_ptr = 0; m_ovf = 0; last_g = -1;
  endtask

  task automatic chk_res(input string tag);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'(m_vld));
    chk({tag, "_res_data"}, res_data, m_data);
    chk({tag, "_res_id"}, 32'(res_id), 32'(m_id));
`ifdef NEGEXT_NEG_OVF_EN
    chk({tag, "_res_ovf"}, 32'(res_ovf), 32'(m_ovf));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    model_reset();
    #1;
    chk_res("reset");
    chk("reset_req0_ready", 32'(req0_ready), 32'(0));
    chk("reset_req1_ready", 32'(req1_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, check readys against the arbitration rules,
  // then after the edge check the result register against the model.
  task automatic step(input logic v0, input logic o0, input logic [31:0] d0,
                      input logic v1, input logic o1, input logic [31:0] d1,
                      input logic rr);
    int g;
    logic [31:0] src;
    logic op;
    longint wide;
    @(negedge clk);
    req0_valid = v0; req0_op = o0; req0_data = d0;
    req1_valid = v1; req1_op = o1; req1_data = d1;
    res_ready = rr;
    #1;
    if (m_vld && !rr)  g = -1;
    else if (v0 && v1) g = m_ptr;
    else if (v0)       g = 0;
    else if (v1)       g = 1;
    else               g = -1;
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    last_g = g;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      src = (g == 1) ? d1 : d0;
      op  = (g == 1) ? o1 : o0;
      if (op) begin
        wide   = (longint'(1) <<< 32) - longint'(src);
        m_data = wide[31:0];
      end else begin
        m_data = src % 32'd65536;
      end
      m_ovf = op && (src == 32'h8000_0000);
      m_id  = g;
      m_vld = 1;
      m_ptr = 1 - g;
    end else if (rr) begin
      m_vld = 0;
    end
    chk_res("model");
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0001;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  bit          pv [2];
  bit          po [2];
  logic [31:0] pd [2];

  initial begin
    model_reset();
    do_reset();

    // Lone requester negates 7.
    step(1, 1, 32'h7, 0, 0, 32'h0, 1);
    chk("t1_req0_ready", 32'(last_g), 32'(0));
    chk("t1_res_valid", 32'(res_valid), 32'(1));
    chk("t1_res_data", res_data, 32'hFFFF_FFF9);
    chk("t1_res_id", 32'(res_id), 32'(0));
    step(0, 0, 32'h0, 0, 0, 32'h0, 1);
    chk("t1_drain", 32'(res_valid), 32'(0));
    chk("t1_hold_data", res_data, 32'hFFFF_FFF9);

    // Contention alternates winners with no bubbles.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 32'hFFFF_FFFF, 1, 1, 32'h1, 1);
      chk("t2_valid", 32'(res_valid), 32'(1));
      chk("t2_id", 32'(res_id), 32'(k % 2));
      chk("t2_data", res_data, (k % 2 == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    end

    // Backpressure with req1 waiting.
    step(0, 0, 32'h0, 0, 0, 32'h0, 1);
    step(1, 0, 32'h0001_1234, 0, 0, 32'h0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 32'h0, 1, 1, 32'h2, 0);
      chk("t3_stall_ready", 32'(req1_ready), 32'(0));
      chk("t3_stall_data", res_data, 32'h0000_1234);
      chk("t3_stall_valid", 32'(res_valid), 32'(1));
    end
    step(0, 0, 32'h0, 1, 1, 32'h2, 1);
    chk("t3_release_ready", 32'(last_g), 32'(1));
    chk("t3_release_data", res_data, 32'hFFFF_FFFE);
    chk("t3_release_id", 32'(res_id), 32'(1));

    // Arithmetic boundaries.
    step(1, 1, 32'h0, 0, 0, 32'h0, 1);
    chk("t4_neg0", res_data, 32'h0);
    step(0, 0, 32'h0, 1, 1, 32'h8000_0000, 1);
    chk("t4_negmin", res_data, 32'h8000_0000);
`ifdef NEGEXT_NEG_OVF_EN
    chk("t4_ovf_set", 32'(res_ovf), 32'(1));
`endif
    step(1, 1, 32'h1, 0, 0, 32'h0, 1);
    chk("t4_neg1", res_data, 32'hFFFF_FFFF);
`ifdef NEGEXT_NEG_OVF_EN
    chk("t4_ovf_clr", 32'(res_ovf), 32'(0));
`endif

    // Asynchronous reset mid-operation.
    step(0, 0, 32'h0, 1, 1, 32'h5, 0);
    chk("t5_pre_valid", 32'(res_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", 32'(res_valid), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 32'hABCD_1234, 1, 1, 32'h3, 1);
    chk("t5_first_winner", 32'(last_g), 32'(0));
    chk("t5_first_data", res_data, 32'h0000_1234);

    // Randomized traffic; requesters hold their operation until accepted.
    pv[0] = 0; pv[1] = 0; po[0] = 0; po[1] = 0; pd[0] = '0; pd[1] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] && $urandom_range(0, 2) != 0) begin
          pv[n] = 1;
          po[n] = 1'($urandom_range(0, 1));
          pd[n] = rnd_data();
        end
      end
      step(pv[0], po[0], pd[0], pv[1], po[1], pd[1], $urandom_range(0, 3) != 0);
      if (last_g >= 0) pv[last_g] = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
